// File: rtl/pong_pkg.sv
// Shared Pong definitions: state encoding, score nibble layout, screen geometry
// and a saturating score increment.
package pong_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SERVE = S_SERVE,
        ST_PLAY  = S_PLAY,
        ST_POINT = S_POINT,
        ST_PAUSE = S_PAUSE,
        ST_OVER  = S_OVER
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Score bus layout: opponent in the upper nibble, player in the lower.
    localparam int OPP_MSB = 7;
    localparam int PLR_MSB = 3;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the game sequencer and the rest of the Pong core.
// Events are single-cycle pulses sampled on the rising clk edge; there is no
// backpressure, so a pulse is consumed (or dropped) in the cycle it appears.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       evt_left_miss;
    logic       evt_right_miss;
    logic       evt_paddle_hit;
    logic       ball_center;
    logic       ball_move_en;
    logic       paddle_move_en;
    logic       serve_dir;
    logic [2:0] speed;
    logic [7:0] score;
    logic [2:0] state;
    logic       game_over;
    logic       winner;

    modport master (
        input  frame_tick, start_btn, pause_btn,
        input  evt_left_miss, evt_right_miss, evt_paddle_hit,
        output ball_center, ball_move_en, paddle_move_en, serve_dir,
        output speed, score, state, game_over, winner
    );

    modport slave (
        output frame_tick, start_btn, pause_btn,
        output evt_left_miss, evt_right_miss, evt_paddle_hit,
        input  ball_center, ball_move_en, paddle_move_en, serve_dir,
        input  speed, score, state, game_over, winner
    );
endinterface

// File: rtl/pong_btn_edge.sv
// Rising-edge detector for an already-synchronised button level. History resets
// to 1 so a button held through reset never produces an edge.
module pong_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= 1'b1;
        else        prev_q <= level;
    end

    assign rise = level & ~prev_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: state machine, scores, serve direction and ball speed.
// All outputs are registered from the next-state decode.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE        = 7,
    parameter int SERVE_FRAMES     = 60,
    parameter int POINT_FRAMES     = 30,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int SPEED_MAX        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pong_game_ctrl_if.master bus
);
    localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FW        = $clog2(FRAME_MAX + 1);
    localparam int HW        = $clog2(HITS_PER_SPEEDUP + 1);

    localparam logic [FW-1:0] SERVE_LOAD = FW'(SERVE_FRAMES);
    localparam logic [FW-1:0] POINT_LOAD = FW'(POINT_FRAMES);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_SPEEDUP - 1);
    localparam logic [2:0]    SPD_MAX    = 3'(SPEED_MAX);
    localparam logic [3:0]    WIN_NIB    = 4'(WIN_SCORE);

    state_t        state_q, state_d;
    logic [7:0]    score_q, score_d;
    logic [2:0]    speed_q, speed_d;
    logic          dir_q, dir_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          winner_q, winner_d;
    logic          center_q, center_d;
    logic          move_q, move_d;
    logic          paddle_q, paddle_d;
    logic          over_q, over_d;

    logic start_rise, pause_rise;

    pong_btn_edge u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.start_btn),
        .rise  (start_rise)
    );

    pong_btn_edge u_pause_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bus.pause_btn),
        .rise  (pause_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            score_q  <= 8'h00;
            speed_q  <= 3'd1;
            dir_q    <= 1'b1;
            hit_q    <= '0;
            frame_q  <= '0;
            winner_q <= 1'b0;
            center_q <= 1'b1;
            move_q   <= 1'b0;
            paddle_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            speed_q  <= speed_d;
            dir_q    <= dir_d;
            hit_q    <= hit_d;
            frame_q  <= frame_d;
            winner_q <= winner_d;
            center_q <= center_d;
            move_q   <= move_d;
            paddle_q <= paddle_d;
            over_q   <= over_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        speed_d  = speed_q;
        dir_d    = dir_q;
        hit_d    = hit_q;
        frame_d  = frame_q;
        winner_d = winner_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    score_d  = 8'h00;
                    speed_d  = 3'd1;
                    hit_d    = '0;
                    dir_d    = 1'b1;
                    frame_d  = SERVE_LOAD;
                    winner_d = 1'b0;
                end
            end
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_q == FRAME_ONE) state_d = ST_PLAY;
                    else                      frame_d = frame_q - FRAME_ONE;
                end
            end
            ST_PLAY: begin
                // Fixed priority: left miss, right miss, pause, paddle hit.
                if (bus.evt_left_miss || bus.evt_right_miss) begin
                    if (bus.evt_left_miss) begin
                        score_d[PLR_MSB -: 4] = sat_inc4(score_q[PLR_MSB -: 4]);
                        dir_d = 1'b0;
                    end else begin
                        score_d[OPP_MSB -: 4] = sat_inc4(score_q[OPP_MSB -: 4]);
                        dir_d = 1'b1;
                    end
                    state_d = ST_POINT;
                    speed_d = 3'd1;
                    hit_d   = '0;
                    frame_d = POINT_LOAD;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end else if (bus.evt_paddle_hit) begin
                    if (hit_q == HIT_LAST) begin
                        hit_d   = '0;
                        speed_d = (speed_q < SPD_MAX) ? speed_q + 3'd1 : speed_q;
                    end else begin
                        hit_d = hit_q + HW'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_rise) state_d = ST_PLAY;
            end
            ST_POINT: begin
                if (bus.frame_tick) begin
                    if (frame_q == FRAME_ONE) begin
                        if (score_q[PLR_MSB -: 4] == WIN_NIB || score_q[OPP_MSB -: 4] == WIN_NIB) begin
                            state_d  = ST_OVER;
                            winner_d = (score_q[PLR_MSB -: 4] == WIN_NIB);
                        end else begin
                            state_d = ST_SERVE;
                            frame_d = SERVE_LOAD;
                        end
                    end else begin
                        frame_d = frame_q - FRAME_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        center_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
        move_d   = (state_d == ST_PLAY);
        paddle_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
        over_d   = (state_d == ST_OVER);
    end

    assign bus.state          = state_q;
    assign bus.score          = score_q;
    assign bus.speed          = speed_q;
    assign bus.serve_dir      = dir_q;
    assign bus.winner         = winner_q;
    assign bus.ball_center    = center_q;
    assign bus.ball_move_en   = move_q;
    assign bus.paddle_move_en = paddle_q;
    assign bus.game_over      = over_q;
endmodule
